clock_time_counter: RTL and testbench

- Upstream timekeeping stage for the four-digit multiplexed seven-segment driver.
- Generates a 1 Hz tick from the board clock and keeps a 24-hour HH:MM time in BCD.
- Drives four BCD digit outputs that wire directly to the driver's four digit inputs, ordered left to right as hr_tens, hr_ones, min_tens, min_ones.
- Provides a set mode with increment buttons, a colon-blink output and a one-cycle seconds tick.

---
 rtl/clock_time_counter.sv | 222 ++++++++++++++++++++++
 tb/tb_clock_time_counter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
`timescale 1ns/1ps
// clock_time_counter
// -----------------------------------------------------------------------------
// Timekeeping stage feeding the four-digit multiplexed seven-segment driver.
// Divides the board clock down to a 1 Hz tick and keeps a 24-hour HH:MM time
// in BCD, with a set mode driven by two increment buttons.
//
// Ports
//   clk       system clock
//   clr       asynchronous, active-high reset (time 00:00, all state cleared)
//   set_mode  level, 1 = time-set mode (asynchronous to clk)
//   inc_min   button, +1 minute per press while in set mode (asynchronous)
//   inc_hr    button, +1 hour per press while in set mode (asynchronous)
//   hr_tens   BCD hours tens   (0-2)
//   hr_ones   BCD hours ones   (0-9, 0-3 when hr_tens = 2)
//   min_tens  BCD minutes tens (0-5)
//   min_ones  BCD minutes ones (0-9)
//   sec_tick  one-clk pulse per elapsed second (run mode only)
//   colon     colon enable: 50% blink at 1 Hz in run mode, steady 1 in set mode
//
// Parameters
//   TICK_DIV  clk cycles per second (even, >= 4)
//   PW        prescaler width, derived from TICK_DIV
// -----------------------------------------------------------------------------
module clock_time_counter #(
    parameter int TICK_DIV = 100000000,
    parameter int PW       = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       sec_tick,
    output logic       colon
);

    localparam logic [PW-1:0] PRESC_TOP  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);

    // -------------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer on every asynchronous input,
    // bit 0 = set_mode, bit 1 = inc_min, bit 2 = inc_hr.
    // -------------------------------------------------------------------------
    logic [2:0] async_vec;
    logic [2:0] sync_vec;
    logic [1:0] press_vec;

    assign async_vec = {inc_hr, inc_min, set_mode};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_vec[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_vec[gi] = sync_reg;
        end

        // Rising-edge detect on the two buttons: one pulse per press no
        // matter how long the button is held.
        for (gi = 0; gi < 2; gi++) begin : g_edge
            logic prev_reg;
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    prev_reg <= 1'b0;
                end else begin
                    prev_reg <= sync_vec[gi+1];
                end
            end
            assign press_vec[gi] = sync_vec[gi+1] & ~prev_reg;
        end
    endgenerate

    logic set_s;
    logic inc_min_p;
    logic inc_hr_p;

    assign set_s     = sync_vec[0];
    assign inc_min_p = press_vec[0];
    assign inc_hr_p  = press_vec[1];

    // -------------------------------------------------------------------------
    // BCD increment helpers. An out-of-range field (never reachable from
    // reset) is forced back to 00 by its next increment.
    // -------------------------------------------------------------------------
    // Returns {carry_to_hours, tens, ones}.
    function automatic logic [8:0] min_step(input logic [3:0] tens,
                                            input logic [3:0] ones);
        if (tens > 4'd5 || ones > 4'd9) begin
            min_step = 9'h000;
        end else if (tens == 4'd5 && ones == 4'd9) begin
            min_step = {1'b1, 8'h00};
        end else if (ones == 4'd9) begin
            min_step = {1'b0, tens + 4'd1, 4'd0};
        end else begin
            min_step = {1'b0, tens, ones + 4'd1};
        end
    endfunction

    // Returns {tens, ones}. The 23 -> 00 wrap is tested before the ones wrap.
    function automatic logic [7:0] hr_step(input logic [3:0] tens,
                                           input logic [3:0] ones);
        if (tens > 4'd2 || ones > 4'd9 || (tens == 4'd2 && ones >= 4'd3)) begin
            hr_step = 8'h00;
        end else if (ones == 4'd9) begin
            hr_step = {tens + 4'd1, 4'd0};
        end else begin
            hr_step = {tens, ones + 4'd1};
        end
    endfunction

    // -------------------------------------------------------------------------
    // Time state
    // -------------------------------------------------------------------------
    logic [PW-1:0] presc_reg,    presc_next;
    logic [5:0]    sec_reg,      sec_next;
    logic [3:0]    min_ones_reg, min_ones_next;
    logic [3:0]    min_tens_reg, min_tens_next;
    logic [3:0]    hr_ones_reg,  hr_ones_next;
    logic [3:0]    hr_tens_reg,  hr_tens_next;
    logic          sec_tick_reg, sec_tick_next;
    logic          colon_reg,    colon_next;

    logic          tick;
    logic          sec_carry;
    logic [8:0]    min_inc;
    logic [7:0]    hr_inc;

    always_comb begin
        min_inc       = min_step(min_tens_reg, min_ones_reg);
        hr_inc        = hr_step(hr_tens_reg, hr_ones_reg);
        // Gating by set_s drops a tick that lands on the first set-mode clk.
        tick          = !set_s && (presc_reg == PRESC_TOP);
        sec_carry     = 1'b0;

        presc_next    = presc_reg;
        sec_next      = sec_reg;
        min_ones_next = min_ones_reg;
        min_tens_next = min_tens_reg;
        hr_ones_next  = hr_ones_reg;
        hr_tens_next  = hr_tens_reg;
        sec_tick_next = 1'b0;
        colon_next    = colon_reg;

        if (set_s) begin
            // Holding prescaler and seconds at 0 means counting restarts
            // cleanly, a full second later, once set mode is left.
            presc_next    = '0;
            sec_next      = '0;
            sec_tick_next = 1'b0;
            colon_next    = 1'b1;
            // Minutes wrap on their own here; the carry is discarded.
            if (inc_min_p) begin
                {min_tens_next, min_ones_next} = min_inc[7:0];
            end
            if (inc_hr_p) begin
                {hr_tens_next, hr_ones_next} = hr_inc;
            end
        end else begin
            presc_next    = (presc_reg == PRESC_TOP) ? '0 : presc_reg + PW'(1);
            sec_tick_next = tick;
            colon_next    = (presc_reg < PRESC_HALF);
            if (tick) begin
                if (sec_reg >= 6'd59) begin
                    sec_next  = '0;
                    sec_carry = 1'b1;
                end else begin
                    sec_next  = sec_reg + 6'd1;
                end
            end
            if (sec_carry) begin
                {min_tens_next, min_ones_next} = min_inc[7:0];
                if (min_inc[8]) begin
                    {hr_tens_next, hr_ones_next} = hr_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_reg    <= '0;
            sec_reg      <= '0;
            min_ones_reg <= '0;
            min_tens_reg <= '0;
            hr_ones_reg  <= '0;
            hr_tens_reg  <= '0;
            sec_tick_reg <= 1'b0;
            colon_reg    <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            sec_reg      <= sec_next;
            min_ones_reg <= min_ones_next;
            min_tens_reg <= min_tens_next;
            hr_ones_reg  <= hr_ones_next;
            hr_tens_reg  <= hr_tens_next;
            sec_tick_reg <= sec_tick_next;
            colon_reg    <= colon_next;
        end
    end

    assign hr_tens  = hr_tens_reg;
    assign hr_ones  = hr_ones_reg;
    assign min_tens = min_tens_reg;
    assign min_ones = min_ones_reg;
    assign sec_tick = sec_tick_reg;
    assign colon    = colon_reg;

endmodule

// File: tb/tb_clock_time_counter.sv
`timescale 1ns/1ps
// Testbench for clock_time_counter (TICK_DIV = 4).
// Reference model keeps the time of day as a plain seconds count and the
// run time as a clk count since counting (re)started; expected digits,
// sec_tick and colon are derived from those with ordinary arithmetic.
module tb_clock_time_counter;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hr;
    logic [3:0] hr_tens;
    logic [3:0] hr_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic       sec_tick;
    logic       colon;

    clock_time_counter #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .clr      (clr),
        .set_mode (set_mode),
        .inc_min  (inc_min),
        .inc_hr   (inc_hr),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tick (sec_tick),
        .colon    (colon)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    int m_tod;      // seconds since midnight
    int m_run;      // clk edges since counting (re)started
    bit m_tick;
    bit m_colon;
    bit set_h[2];   // input samples: [0] = last edge, [1] = the edge before
    bit min_h[3];
    bit hr_h[3];

    function automatic void model_reset();
        m_tod   = 0;
        m_run   = 0;
        m_tick  = 1'b0;
        m_colon = 1'b0;
        for (int i = 0; i < 2; i++) set_h[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            min_h[i] = 1'b0;
            hr_h[i]  = 1'b0;
        end
    endfunction

    // Called once per rising clk edge with the inputs as they were at that edge.
    function automatic void model_step();
        bit sm, mp, hp;
        int h, m;
        if (clr) begin
            model_reset();
            return;
        end
        sm = set_h[1];
        mp = min_h[1] && !min_h[2];
        hp = hr_h[1] && !hr_h[2];
        if (sm) begin
            h = m_tod / 3600;
            m = (m_tod / 60) % 60;
            if (mp) m = (m + 1) % 60;
            if (hp) h = (h + 1) % 24;
            m_tod   = h * 3600 + m * 60;
            m_run   = 0;
            m_tick  = 1'b0;
            m_colon = 1'b1;
        end else begin
            m_run   = m_run + 1;
            m_tick  = (m_run % TICK_DIV) == 0;
            m_colon = ((m_run - 1) % TICK_DIV) < (TICK_DIV / 2);
            if (m_tick) m_tod = (m_tod + 1) % 86400;
        end
        set_h[1] = set_h[0];  set_h[0] = set_mode;
        min_h[2] = min_h[1];  min_h[1] = min_h[0];  min_h[0] = inc_min;
        hr_h[2]  = hr_h[1];   hr_h[1]  = hr_h[0];   hr_h[0]  = inc_hr;
    endfunction

    function automatic logic [15:0] model_digits();
        int h, m;
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {hr_tens, hr_ones, min_tens, min_ones};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s at %0t: got %h required %h", name, $time, got, req);
    endtask

    task automatic check_all(input string tag);
        check(tag, {14'b0, dut_digits(), sec_tick, colon},
                   {14'b0, model_digits(), m_tick, m_colon});
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Press inc_min n_min times and inc_hr n_hr times, overlapping them.
    task automatic press_n(input int n_min, input int n_hr);
        int n;
        n = (n_min > n_hr) ? n_min : n_hr;
        for (int i = 0; i < n; i++) begin
            inc_min = (i < n_min);
            inc_hr  = (i < n_hr);
            cycle("press");
            cycle("press");
            inc_min = 1'b0;
            inc_hr  = 1'b0;
            cycle("press");
            cycle("press");
        end
    endtask

    typedef struct {
        int          n_min;
        int          n_hr;
        logic [15:0] exp_digits;
    } set_vec_t;

    set_vec_t    tbl[5];
    logic [11:0] tick_pat;
    logic [11:0] colon_pat;
    logic [15:0] prev;
    int          ticks;
    bit          done;
    bit          seen;
    bit          any_tick;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Set-mode vectors, applied in order from 00:00.
        tbl[0] = '{n_min: 5,  n_hr: 0,  exp_digits: 16'h0005};
        tbl[1] = '{n_min: 0,  n_hr: 3,  exp_digits: 16'h0305};
        tbl[2] = '{n_min: 55, n_hr: 0,  exp_digits: 16'h0300}; // 59->00, no hour carry
        tbl[3] = '{n_min: 0,  n_hr: 21, exp_digits: 16'h0000}; // 23->00
        tbl[4] = '{n_min: 59, n_hr: 23, exp_digits: 16'h2359};
        // clk k after reset release -> bit k-1
        tick_pat  = 12'b1000_1000_1000;
        colon_pat = 12'b0011_0011_0011;

        clr      = 1'b1;
        set_mode = 1'b0;
        inc_min  = 1'b0;
        inc_hr   = 1'b0;
        model_reset();

        // Reset and first ticks
        repeat (3) cycle("reset");
        clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle("first_ticks");
            check("sec_tick_pattern", sec_tick, tick_pat[k-1]);
            check("colon_pattern", colon, colon_pat[k-1]);
        end
        $display("first ticks: 12 clk checked");

        // Set-mode vectors
        set_mode = 1'b1;
        repeat (4) cycle("enter_set");
        for (int i = 0; i < 5; i++) begin
            press_n(tbl[i].n_min, tbl[i].n_hr);
            check("set_vec", dut_digits(), tbl[i].exp_digits);
            $display("set vec %0d: +%0d min +%0d hr -> %h", i, tbl[i].n_min, tbl[i].n_hr, dut_digits());
        end

        // Rollover 23:59:59 -> 00:00:00 on the 60th sec_tick
        set_mode = 1'b0;
        ticks = 0;
        done  = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            prev = dut_digits();
            cycle("rollover");
            if (sec_tick) begin
                ticks++;
                if (ticks == 60) begin
                    check("rollover_prev", prev, 16'h2359);
                    check("rollover_now", dut_digits(), 16'h0000);
                    done = 1'b1;
                end
            end
        end
        if (!done) check("rollover_bound", ticks, 60);
        $display("rollover: %0d ticks, now %h", ticks, dut_digits());

        // Minute carry: 600 s from 00:00:00
        seen = 1'b0;
        for (int i = 0; i < 600 * TICK_DIV; i++) begin
            prev = dut_digits();
            cycle("minute_carry");
            if (prev == 16'h0009 && dut_digits() == 16'h0010) seen = 1'b1;
        end
        check("carry_0009_to_0010", seen, 1);
        check("after_600s", dut_digits(), 16'h0010);
        $display("minute carry: now %h", dut_digits());

        // Asynchronous clear mid-second
        cycle("mid_second");
        cycle("mid_second");
        #3 clr = 1'b1;
        #1 check("async_clr", {dut_digits(), sec_tick, colon}, 0);
        model_reset();
        repeat (2) cycle("in_reset");
        clr = 1'b0;
        $display("async clr: outputs %h", {dut_digits(), sec_tick, colon});

        // Held button, then simultaneous presses
        set_mode = 1'b1;
        repeat (4) cycle("enter_set");
        inc_min = 1'b1;
        repeat (50) cycle("hold_min");
        inc_min = 1'b0;
        repeat (4) cycle("hold_min");
        check("held_min", dut_digits(), 16'h0001);
        inc_min = 1'b1;
        inc_hr  = 1'b1;
        repeat (2) cycle("both_press");
        inc_min = 1'b0;
        inc_hr  = 1'b0;
        repeat (3) cycle("both_press");
        check("simul_press", dut_digits(), 16'h0102);
        $display("held + simultaneous: now %h", dut_digits());

        // set_mode landing on the tick that would complete the minute
        set_mode = 1'b0;
        ticks = 0;
        for (int i = 0; i < 400 && ticks < 59; i++) begin
            cycle("to_59s");
            if (sec_tick) ticks++;
        end
        check("reach_59s", ticks, 59);
        for (int i = 0; i < 8 && (m_run % TICK_DIV) != 1; i++) cycle("align");
        set_mode = 1'b1;   // synchronized value arrives on the tick edge
        any_tick = 1'b0;
        repeat (6) begin
            cycle("tick_drop");
            if (sec_tick) any_tick = 1'b1;
        end
        check("dropped_tick_pulse", any_tick, 0);
        check("dropped_tick_time", dut_digits(), 16'h0102);
        $display("tick drop: now %h", dut_digits());

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) set_mode = ~set_mode;
            if ($urandom_range(0, 3) == 0)  inc_min  = ~inc_min;
            if ($urandom_range(0, 3) == 0)  inc_hr   = ~inc_hr;
            cycle("random");
        end
        $display("random: 1500 clk, now %h", dut_digits());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
